piso_rr_scheduler: RTL

Round-robin scheduler that shares one parallel-in, serial-out shift register among `NUM_REQ` requesters. It accepts one `DATA_WIDTH` word per grant through a valid/ready handshake and loads it into the serializer. It then shifts the word out LSB-first with framing strobes. It sits between the parallel word producers and the single-bit serial link, and owns all sequencing of the serializer's load and shift controls.

---
 rtl/piso_rr_scheduler_pkg.sv | 40 ++++
 rtl/piso_rr_scheduler_shift_reg.sv | 27 ++
 rtl/piso_rr_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/piso_rr_scheduler_pkg.sv
// piso_rr_scheduler_pkg: shared state encoding and helpers for the
// round-robin PISO scheduler (index width, round-robin winner pick).
package piso_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Widest requester vector the winner search handles.
  localparam int MAX_REQ = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of valid at or after ptr, wrapping at n.
  function automatic void rr_pick(
    input  logic [MAX_REQ-1:0] valid,
    input  int                 n,
    input  int                 ptr,
    output logic               found,
    output int                 idx
  );
    int k;
    found = 1'b0;
    idx   = 0;
    for (int o = 0; o < MAX_REQ; o++) begin
      k = ptr + o;
      if (k >= n) k = k - n;
      if (o < n && !found &&
          |(valid & (MAX_REQ'(1) << k))) begin
        found = 1'b1;
        idx   = k;
      end
    end
  endfunction

endpackage

// File: rtl/piso_rr_scheduler_shift_reg.sv
// piso_shift_reg: parallel-load, LSB-first serializer.
// Ports: clk, resetn (sync, active-low), din/din_en load, dout = bit 0.
module piso_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] din,
  input  logic         din_en,
  output logic         dout
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
    end else if (din_en) begin
      q <= din;
    end else begin
      q <= {1'b0, q[W-1:1]};
    end
  end

  assign dout = q[0];

endmodule

// File: rtl/piso_rr_scheduler.sv
// piso_rr_scheduler: round-robin arbiter feeding one shared serializer.
// Ports: clk, resetn (sync, active-low); req_valid/req_data/req_ready
// per-requester handshake (req_ready combinational, one-hot);
// dout/dout_valid/sof/eof serial frame, grant_id frame source, busy.
// Option: define PISO_RR_SCHEDULER_PARITY_EN for a trailing parity bit.
module piso_rr_scheduler
  import piso_rr_scheduler_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REQ    = 4,
  localparam int IDX_W      = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          dout,
  output logic                          dout_valid,
  output logic                          sof,
  output logic                          eof,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
);

  localparam int CNT_W = idx_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] TOP =
    IDX_W'(NUM_REQ - 1);

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      grant_q;
  logic [IDX_W-1:0]      hs_idx;
  logic [CNT_W-1:0]      cnt_q;
  logic                  win_found;
  int                    win_idx;
  logic                  hs;
  logic                  last_bit;
  logic                  accept_win;
  logic                  sh_dout;
  logic [DATA_WIDTH-1:0] ld_word;

  assign last_bit = (state_q == SHIFT)
                 && (cnt_q == LAST);

  // With parity the last data bit is not the
  // final frame cycle; the parity cycle is.
`ifdef PISO_RR_SCHEDULER_PARITY_EN
  assign accept_win = (state_q == IDLE)
                   || (state_q == PARITY);
`else
  assign accept_win = (state_q == IDLE)
                   || last_bit;
`endif

  always_comb begin
    rr_pick(MAX_REQ'(req_valid), NUM_REQ,
            int'(ptr_q), win_found, win_idx);
  end

  assign hs_idx = IDX_W'(win_idx);

  always_comb begin
    req_ready = '0;
    if (resetn && accept_win && win_found) begin
      req_ready[hs_idx] = 1'b1;
    end
  end

  // req_ready is only raised on a valid winner.
  assign hs = |req_ready;

  always_comb begin
    ld_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        ld_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  piso_shift_reg #(
    .W (DATA_WIDTH)
  ) u_shift (
    .clk    (clk),
    .resetn (resetn),
    .din    (ld_word),
    .din_en (hs),
    .dout   (sh_dout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (hs) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef PISO_RR_SCHEDULER_PARITY_EN
          state_d = PARITY;
`else
          state_d = hs ? SHIFT : IDLE;
`endif
        end
      end
      PARITY: begin
        state_d = hs ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        grant_q <= hs_idx;
        ptr_q   <= (hs_idx == TOP) ? '0
                 : hs_idx + 1'b1;
        cnt_q   <= '0;
      end else if (state_q == SHIFT && !last_bit) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef PISO_RR_SCHEDULER_PARITY_EN
  logic par_q;

  // Restarts on the first bit of each frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      par_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      par_q <= ((cnt_q == '0) ? 1'b0 : par_q)
             ^ sh_dout;
    end
  end
`endif

  always_comb begin
    dout       = 1'b0;
    dout_valid = 1'b0;
    sof        = 1'b0;
    eof        = 1'b0;
    unique case (1'b1)
      (state_q == SHIFT): begin
        dout       = sh_dout;
        dout_valid = 1'b1;
        sof        = (cnt_q == '0);
`ifndef PISO_RR_SCHEDULER_PARITY_EN
        eof        = last_bit;
`endif
      end
`ifdef PISO_RR_SCHEDULER_PARITY_EN
      (state_q == PARITY): begin
        dout       = par_q;
        dout_valid = 1'b1;
        eof        = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy     = dout_valid;
  assign grant_id = grant_q;

endmodule
